// File: rtl/inst_stream_encoder.sv
// RV32IM instruction encoder: symbolic ops in, packed instruction words out to the
// instruction-memory write port at sequential addresses, behind one output register.
module inst_stream_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [5:0]  op_kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_addr,
    output logic        full,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_KIND  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_ALIGN = 2'b11;

    logic [CW-1:0] cnt;
    logic [31:0]   enc_word;
    logic [1:0]    enc_err;
    logic [2:0]    f3;
    logic [5:0]    k;
    logic          ok12, ok13, ok21;

    // Sign-extension checks: all bits above the field's sign bit match it.
    assign ok12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign ok13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign ok21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word = '0;
        enc_err  = ERR_NONE;
        f3       = '0;
        k        = op_kind;
        if (op_kind <= 6'd9) begin
            case (op_kind)
                6'd0, 6'd1: f3 = 3'd0;
                6'd2:       f3 = 3'd1;
                6'd3:       f3 = 3'd2;
                6'd4:       f3 = 3'd3;
                6'd5:       f3 = 3'd4;
                6'd6, 6'd7: f3 = 3'd5;
                6'd8:       f3 = 3'd6;
                default:    f3 = 3'd7;
            endcase
            enc_word = {((op_kind == 6'd1) || (op_kind == 6'd7)) ? 7'b0100000 : 7'b0000000,
                        rs2, rs1, f3, rd, OPC_OP};
        end else if (op_kind <= 6'd17) begin
            k        = op_kind - 6'd10;
            f3       = k[2:0];
            enc_word = {7'b0000001, rs2, rs1, f3, rd, OPC_OP};
        end else if (op_kind <= 6'd23) begin
            case (op_kind)
                6'd18:   f3 = 3'd0;
                6'd19:   f3 = 3'd2;
                6'd20:   f3 = 3'd3;
                6'd21:   f3 = 3'd4;
                6'd22:   f3 = 3'd6;
                default: f3 = 3'd7;
            endcase
            enc_word = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
            if (!ok12) enc_err = ERR_RANGE;
        end else if (op_kind <= 6'd26) begin
            f3       = (op_kind == 6'd24) ? 3'd1 : 3'd5;
            enc_word = {(op_kind == 6'd26) ? 7'b0100000 : 7'b0000000, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
            if (|imm[31:5]) enc_err = ERR_RANGE;
        end else if (op_kind <= 6'd31) begin
            k        = op_kind - 6'd27;
            f3       = (k[2:0] < 3'd3) ? k[2:0] : k[2:0] + 3'd1;
            enc_word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            if (!ok12) enc_err = ERR_RANGE;
        end else if (op_kind <= 6'd34) begin
            k        = op_kind - 6'd32;
            f3       = k[2:0];
            enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            if (!ok12) enc_err = ERR_RANGE;
        end else if (op_kind <= 6'd40) begin
            // BEQ/BNE map to 000/001, the rest skip the unused 010/011 codes.
            k        = op_kind - 6'd35;
            f3       = (k[2:0] < 3'd2) ? k[2:0] : k[2:0] + 3'd2;
            enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            if (!ok13)       enc_err = ERR_RANGE;
            else if (imm[0]) enc_err = ERR_ALIGN;
        end else begin
            case (op_kind)
                6'd41: begin
                    enc_word = {imm[31:12], rd, OPC_LUI};
                    if (|imm[11:0]) enc_err = ERR_RANGE;
                end
                6'd42: begin
                    enc_word = {imm[31:12], rd, OPC_AUIPC};
                    if (|imm[11:0]) enc_err = ERR_RANGE;
                end
                6'd43: begin
                    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                    if (!ok21)       enc_err = ERR_RANGE;
                    else if (imm[0]) enc_err = ERR_ALIGN;
                end
                6'd44: begin
                    enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
                    if (!ok12) enc_err = ERR_RANGE;
                end
                6'd45: begin
                    enc_word = {imm[11:0], rs1, 3'b001, rd, OPC_SYSTEM};
                    if (|imm[31:12]) enc_err = ERR_RANGE;
                end
                6'd46:   enc_word = 32'h3020_0073;
                default: enc_err  = ERR_KIND;
            endcase
        end
    end

    // cnt counts drained words; adding the held word gives the reserved total.
    assign full      = (32'(cnt) + 32'(inst_valid)) == 32'(DEPTH);
    assign op_ready  = !full && (!inst_valid || inst_ready);
    assign inst_addr = BASE_ADDR + (32'(cnt) << 2);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt        <= '0;
            inst_valid <= 1'b0;
            inst_word  <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            if (inst_valid && inst_ready) begin
                cnt        <= cnt + CW'(1);
                inst_valid <= 1'b0;
            end
            if (op_valid && op_ready) begin
                if (enc_err == ERR_NONE) begin
                    inst_valid <= 1'b1;
                    inst_word  <= enc_word;
                end else begin
                    err <= 1'b1;
                    if (!err) err_code <= enc_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_stream_encoder.sv
// Bench for inst_stream_encoder: vector table plus hand sequences, with a queue
// scoreboard that predicts every emitted word/address and the handshake state.
module tb_inst_stream_encoder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, clear = 1'b0, op_valid = 1'b0, inst_ready = 1'b1;
    logic [5:0]  op_kind = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        op_ready, inst_valid, full, err;
    logic [31:0] inst_word, inst_addr;
    logic [1:0]  err_code;

    inst_stream_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
        .op_kind(op_kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
        .inst_addr(inst_addr), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    int checks = 0, errors = 0;
    int exp_n = 0, n_acc = 0, n_pop = 0;
    exp_t q[$];
    logic        m_err = 1'b0;
    logic [1:0]  m_code = 2'b00;
    logic [31:0] cur_word = '0;
    logic [1:0]  cur_code = 2'b00;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: checks state before this edge's handshakes, then pops/pushes.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            q.delete();
            exp_n  = 0;
            m_err  = 1'b0;
            m_code = 2'b00;
        end else begin
            chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
            chk("full", 32'(full), 32'(exp_n == DEPTH));
            chk("op_ready", 32'(op_ready), 32'((exp_n < DEPTH) && (q.size() == 0 || inst_ready)));
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            if (inst_valid && q.size() != 0) begin
                chk("inst_word", inst_word, q[0].word);
                chk("inst_addr", inst_addr, q[0].addr);
                if (inst_ready) begin
                    void'(q.pop_front());
                    n_pop++;
                end
            end
            if (op_valid && op_ready) begin
                n_acc++;
                if (cur_code == 2'b00) begin
                    q.push_back('{cur_word, BASE + 32'(exp_n) * 4});
                    exp_n++;
                end else begin
                    if (!m_err) m_code = cur_code;
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [5:0] k, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im,
                        input logic [31:0] w, input logic [1:0] code);
        bit done = 0;
        op_kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im;
        cur_word = w; cur_code = code;
        op_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (op_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        op_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic clear_dut();
        wait_drain();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0;
        tbl[0]  = '{6'd18, 5'd1,  5'd0, 5'd0,  32'd5,          32'h0050_0093}; // ADDI
        tbl[1]  = '{6'd0,  5'd3,  5'd1, 5'd2,  32'd0,          32'h0020_81B3}; // ADD
        tbl[2]  = '{6'd34, 5'd9,  5'd1, 5'd2,  32'd8,          32'h0020_A423}; // SW
        tbl[3]  = '{6'd35, 5'd9,  5'd1, 5'd2,  32'hFFFF_FFFC,  32'hFE20_8EE3}; // BEQ -4
        tbl[4]  = '{6'd10, 5'd5,  5'd6, 5'd7,  32'd0,          32'h0273_02B3}; // MUL
        tbl[5]  = '{6'd41, 5'd10, 5'd3, 5'd4,  32'h1234_5000,  32'h1234_5537}; // LUI
        tbl[6]  = '{6'd46, 5'd31, 5'd7, 5'd9,  32'hDEAD_BEEF,  32'h3020_0073}; // MRET
        tbl[7]  = '{6'd1,  5'd1,  5'd2, 5'd3,  32'd0,          32'h4031_00B3}; // SUB
        tbl[8]  = '{6'd26, 5'd4,  5'd5, 5'd0,  32'd3,          32'h4032_D213}; // SRAI
        tbl[9]  = '{6'd43, 5'd1,  5'd0, 5'd0,  32'd2048,       32'h0010_00EF}; // JAL
        tbl[10] = '{6'd45, 5'd2,  5'd3, 5'd0,  32'h300,        32'h3001_9173}; // CSRRW
        tbl[11] = '{6'd29, 5'd6,  5'd2, 5'd0,  32'hFFFF_FFFF,  32'hFFF1_2303}; // LW -1
        tbl[12] = '{6'd44, 5'd0,  5'd1, 5'd0,  32'd0,          32'h0000_8067}; // JALR
        tbl[13] = '{6'd23, 5'd7,  5'd8, 5'd0,  32'hFFFF_F800,  32'h8004_7393}; // ANDI -2048
        tbl[14] = '{6'd24, 5'd1,  5'd1, 5'd0,  32'd31,         32'h01F0_9093}; // SLLI 31

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_word", inst_word, 32'd0);
        chk("rst_inst_addr", inst_addr, BASE);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            if (exp_n == DEPTH) clear_dut();
            send(tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].word, 2'b00);
        end

        // Back-pressure: one word held, a second request waits behind it.
        clear_dut();
        p0 = n_pop;
        inst_ready = 1'b0;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'b00);
        fork
            send(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 2'b00);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_op_ready", 32'(op_ready), 32'd0);
                    chk("stall_inst_word", inst_word, 32'h0050_0093);
                    chk("stall_inst_addr", inst_addr, BASE);
                end
                @(posedge clk); #1 inst_ready = 1'b1;
            end
        join
        send(6'd10, 5'd5, 5'd6, 5'd7, 32'd0, 32'h0273_02B3, 2'b00);
        wait_drain();
        chk("stall_pops", 32'(n_pop - p0), 32'd3);

        // Rejected requests: consumed, no word, address unchanged, first cause kept.
        p0 = n_pop;
        send(6'd18, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h0, 2'b10);
        send(6'd36, 5'd0, 5'd1, 5'd2, 32'd3,         32'h0, 2'b11);
        send(6'd50, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0, 2'b01);
        send(6'd24, 5'd1, 5'd1, 5'd0, 32'd32,        32'h0, 2'b10);
        send(6'd41, 5'd1, 5'd0, 5'd0, 32'h0000_0123, 32'h0, 2'b10);
        @(negedge clk);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_err_code", 32'(err_code), 32'd2);
        chk("rej_inst_valid", 32'(inst_valid), 32'd0);
        chk("rej_inst_addr", inst_addr, BASE + 32'd12);
        chk("rej_no_pops", 32'(n_pop - p0), 32'd0);

        // Reset while a word is pending drops it and restores every output.
        @(posedge clk); #1 inst_ready = 1'b0;
        send(6'd18, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, 2'b00);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_err_code", 32'(err_code), 32'd0);
        chk("rst2_inst_word", inst_word, 32'd0);
        chk("rst2_inst_addr", inst_addr, BASE);
        chk("rst2_op_ready", 32'(op_ready), 32'd1);
        chk("rst2_full", 32'(full), 32'd0);
        @(posedge clk); #1 inst_ready = 1'b1;

        // Capacity: requests held valid for 10 cycles, only DEPTH get through.
        a0 = n_acc; p0 = n_pop;
        op_kind = 6'd18; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
        cur_word = 32'h0050_0093; cur_code = 2'b00;
        op_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("cap_accepted", 32'(n_acc - a0), 32'd4);
        chk("cap_emitted", 32'(n_pop - p0), 32'd4);
        chk("cap_full", 32'(full), 32'd1);
        chk("cap_op_ready", 32'(op_ready), 32'd0);
        chk("cap_inst_addr", inst_addr, BASE + 32'd16);
        @(posedge clk); #1 op_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_inst_addr", inst_addr, BASE);
        chk("clr_op_ready", 32'(op_ready), 32'd1);
        chk("clr_full", 32'(full), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
